cache_mem_ahb_master: RTL and testbench

Memory-side responder for the cache's word-read interface (mem_rd / mem_addr in, mem_ready / mem_rdata out). It turns each word-read request into one AHB-Lite SINGLE WORD read on the downstream system bus, then returns the data or error to the requester. It sits between the cache AHB slave controller and the backing-memory AHB bus. Reads only, one outstanding transfer, no write path.

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_mem_ahb_master.sv | 127 ++++++++++++
 tb/tb_cache_mem_ahb_master.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the cache memory-side AHB master.
package cache_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } cache_state_e;

endpackage

// File: rtl/cache_mem_ahb_master.sv
// Turns cache word-read requests into single AHB-Lite WORD reads, one outstanding transfer.
// Define CACHE_MEM_RDATA_REG_EN to register the completion (adds a RESP cycle of latency).
module cache_mem_ahb_master
  import cache_pkg::*;
#(
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter bit          IDLE_ADDR_HOLD = 1'b1
) (
  input  logic         i_hclk,
  input  logic         i_hnreset,
  input  logic         i_mem_rd,
  input  logic [29:0]  i_mem_addr,
  input  logic [3:0]   i_hprot,
  output logic         o_mem_ready,
  output logic [31:0]  o_mem_rdata,
  output logic         o_mem_err,
  output logic [31:0]  o_haddr,
  output logic [1:0]   o_htrans,
  output logic         o_hwrite,
  output logic [2:0]   o_hsize,
  output logic [2:0]   o_hburst,
  output logic [3:0]   o_hprot,
  output logic [31:0]  o_hwdata,
  input  logic         i_hready,
  input  logic         i_hresp,
  input  logic [31:0]  i_hrdata,
  output cache_state_e o_dbg_state
);

  cache_state_e state;
  logic [31:0]  addr_q;
  logic [3:0]   hprot_q;
  logic         req_take;

  // A request is only accepted in IDLE; the reset qualifier keeps NONSEQ off the bus during reset.
  assign req_take = (state == ST_IDLE) && i_mem_rd && i_hnreset;

`ifdef CACHE_MEM_RDATA_REG_EN
  logic [31:0] rdata_q;
  logic        err_q;
`endif

  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      hprot_q <= '0;
`ifdef CACHE_MEM_RDATA_REG_EN
      rdata_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_take) begin
            addr_q  <= {i_mem_addr, 2'b00};
            hprot_q <= i_hprot;
            state   <= i_hready ? ST_DATA : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (i_hready) state <= ST_DATA;
        end
        ST_DATA: begin
          if (i_hready) begin
`ifdef CACHE_MEM_RDATA_REG_EN
            err_q   <= (i_hresp == HRESP_ERROR);
            rdata_q <= (i_hresp == HRESP_ERROR) ? ERR_RDATA : i_hrdata;
            state   <= ST_RESP;
`else
            state   <= ST_IDLE;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_htrans    = HTRANS_IDLE;
    o_haddr     = addr_q;
    o_hprot     = hprot_q;
    o_mem_ready = 1'b0;
    o_mem_rdata = '0;
    o_mem_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_take) begin
          o_htrans = HTRANS_NONSEQ;
          o_haddr  = {i_mem_addr, 2'b00};
          o_hprot  = i_hprot;
        end else if (IDLE_ADDR_HOLD == 1'b0) begin
          o_haddr = '0;
        end
      end
      ST_ADDR: begin
        o_htrans = HTRANS_NONSEQ;
      end
      ST_DATA: begin
`ifndef CACHE_MEM_RDATA_REG_EN
        // Completion is passed straight through from the slave in the final data-phase cycle.
        if (i_hready) begin
          o_mem_ready = 1'b1;
          o_mem_err   = (i_hresp == HRESP_ERROR);
          o_mem_rdata = (i_hresp == HRESP_ERROR) ? ERR_RDATA : i_hrdata;
        end
`endif
      end
`ifdef CACHE_MEM_RDATA_REG_EN
      ST_RESP: begin
        o_mem_ready = 1'b1;
        o_mem_rdata = rdata_q;
        o_mem_err   = err_q;
      end
`endif
      default: ;
    endcase
  end

  assign o_hwrite    = 1'b0;
  assign o_hsize     = HSIZE_WORD;
  assign o_hburst    = HBURST_SINGLE;
  assign o_hwdata    = '0;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_cache_mem_ahb_master.sv
// Directed and randomized read transfers against a scripted AHB slave, with scoreboarded completions.
module tb_cache_mem_ahb_master;
  import cache_pkg::*;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  logic         i_hclk = 1'b0;
  logic         i_hnreset;
  logic         i_mem_rd;
  logic [29:0]  i_mem_addr;
  logic [3:0]   i_hprot;
  logic         o_mem_ready;
  logic [31:0]  o_mem_rdata;
  logic         o_mem_err;
  logic [31:0]  o_haddr;
  logic [1:0]   o_htrans;
  logic         o_hwrite;
  logic [2:0]   o_hsize;
  logic [2:0]   o_hburst;
  logic [3:0]   o_hprot;
  logic [31:0]  o_hwdata;
  logic         i_hready;
  logic         i_hresp;
  logic [31:0]  i_hrdata;
  cache_state_e o_dbg_state;

  cache_mem_ahb_master #(.ERR_RDATA(ERR_RDATA), .IDLE_ADDR_HOLD(1'b1)) dut (
    .i_hclk(i_hclk), .i_hnreset(i_hnreset),
    .i_mem_rd(i_mem_rd), .i_mem_addr(i_mem_addr), .i_hprot(i_hprot),
    .o_mem_ready(o_mem_ready), .o_mem_rdata(o_mem_rdata), .o_mem_err(o_mem_err),
    .o_haddr(o_haddr), .o_htrans(o_htrans), .o_hwrite(o_hwrite), .o_hsize(o_hsize),
    .o_hburst(o_hburst), .o_hprot(o_hprot), .o_hwdata(o_hwdata),
    .i_hready(i_hready), .i_hresp(i_hresp), .i_hrdata(i_hrdata),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 i_hclk = ~i_hclk;

  int checks = 0;
  int failures = 0;
  logic [31:0] addr_exp_q[$];
  logic [32:0] exp_q[$];
  logic [31:0] last_haddr = '0;

  task automatic check_eq(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_hclk);
    #1;
  endtask

  // scoreboard: accepted address phases and completions
  always @(negedge i_hclk) begin
    if (i_hnreset) begin
      if (o_htrans == HTRANS_NONSEQ && i_hready) begin
        check_eq("xfer_expected", 33'(addr_exp_q.size() > 0), 33'(1));
        if (addr_exp_q.size() > 0) check_eq("xfer_addr", 33'(o_haddr), 33'(addr_exp_q.pop_front()));
      end
      if (o_mem_ready) begin
        check_eq("ready_expected", 33'(exp_q.size() > 0), 33'(1));
        if (exp_q.size() > 0) check_eq("resp", {o_mem_err, o_mem_rdata}, exp_q.pop_front());
      end else begin
        check_eq("rdata_idle_zero", 33'(o_mem_rdata), 33'(0));
      end
    end
  end

  // driver: one read; aw/dw = address/data-phase wait cycles, drop = release i_mem_rd after the request cycle
  task automatic do_read(input logic [29:0] a, input logic [31:0] d, input logic e,
                         input int aw, input int dw, input logic drop);
    logic [3:0] p;
    logic       last_rdy;
    p = 4'($urandom_range(0, 15));
    addr_exp_q.push_back({a, 2'b00});
    exp_q.push_back({e, e ? ERR_RDATA : d});
    for (int i = 0; i <= aw; i++) begin
      step();
      i_mem_rd   = (i == 0) ? 1'b1 : !drop;
      i_mem_addr = (i == 0 || !drop) ? a : 30'($urandom);
      i_hprot    = p;
      i_hready   = (i == aw);
      i_hresp    = 1'b0;
      i_hrdata   = $urandom;
      @(negedge i_hclk);
      check_eq("htrans_addr", 33'(o_htrans), 33'(HTRANS_NONSEQ));
      check_eq("haddr_addr", 33'(o_haddr), 33'({a, 2'b00}));
      check_eq("hprot_addr", 33'(o_hprot), 33'(p));
      check_eq("hconst", 33'({o_hwrite, o_hsize, o_hburst}), 33'({1'b0, 3'b010, 3'b000}));
      check_eq("hwdata", 33'(o_hwdata), 33'(0));
      check_eq("ready_addr", 33'(o_mem_ready), 33'(0));
    end
    for (int i = 0; i <= dw; i++) begin
      step();
      i_mem_rd   = !drop;
      i_mem_addr = drop ? 30'($urandom) : a;
      i_hready   = (i == dw);
      i_hresp    = e && (i + 1 >= dw);
      i_hrdata   = (i == dw) ? d : $urandom;
`ifdef CACHE_MEM_RDATA_REG_EN
      last_rdy = 1'b0;
`else
      last_rdy = (i == dw);
`endif
      @(negedge i_hclk);
      check_eq("htrans_data", 33'(o_htrans), 33'(HTRANS_IDLE));
      check_eq("haddr_data", 33'(o_haddr), 33'({a, 2'b00}));
      check_eq("hprot_data", 33'(o_hprot), 33'(p));
      check_eq("ready_data", 33'(o_mem_ready), 33'(last_rdy));
    end
`ifdef CACHE_MEM_RDATA_REG_EN
    step();
    i_hready = 1'b1;
    i_hresp  = 1'b0;
    i_hrdata = $urandom;
    @(negedge i_hclk);
    check_eq("htrans_resp", 33'(o_htrans), 33'(HTRANS_IDLE));
    check_eq("ready_resp", 33'(o_mem_ready), 33'(1));
`endif
    last_haddr = {a, 2'b00};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      i_mem_rd   = 1'b0;
      i_mem_addr = 30'($urandom);
      i_hready   = 1'b1;
      i_hresp    = 1'b0;
      i_hrdata   = $urandom;
      @(negedge i_hclk);
      check_eq("htrans_idle", 33'(o_htrans), 33'(HTRANS_IDLE));
      check_eq("haddr_idle_hold", 33'(o_haddr), 33'(last_haddr));
      check_eq("ready_idle", 33'(o_mem_ready), 33'(0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e;
    i_hnreset = 1'b0; i_mem_rd = 1'b0; i_mem_addr = '0; i_hprot = '0;
    i_hready = 1'b1; i_hresp = 1'b0; i_hrdata = '0;
    #12;
    check_eq("rst_htrans", 33'(o_htrans), 33'(HTRANS_IDLE));
    check_eq("rst_haddr", 33'(o_haddr), 33'(0));
    check_eq("rst_hprot", 33'(o_hprot), 33'(0));
    check_eq("rst_ready", 33'({o_mem_ready, o_mem_err}), 33'(0));
    check_eq("rst_rdata", 33'(o_mem_rdata), 33'(0));
    check_eq("rst_state", 33'(o_dbg_state), 33'(ST_IDLE));
    step();
    i_hnreset = 1'b1;
    idle(2);

    // zero-wait, data-phase waits, address stall, error, back-to-back
    do_read(30'h0000_0400, 32'h1234_5678, 1'b0, 0, 0, 1'b0);
    idle(1);
    do_read(30'h0000_0123, 32'hCAFE_0001, 1'b0, 0, 3, 1'b0);
    idle(1);
    do_read(30'h0000_0200, 32'h0BAD_F00D, 1'b0, 1, 0, 1'b0);
    idle(1);
    do_read(30'h0000_0300, 32'h5555_AAAA, 1'b1, 0, 1, 1'b0);
    idle(1);
    do_read(30'h0000_0010, 32'h1111_0010, 1'b0, 0, 0, 1'b0);
    do_read(30'h0000_0011, 32'h1111_0011, 1'b0, 0, 0, 1'b0);
    idle(2);
    do_read(30'h0000_0777, 32'h7777_0001, 1'b0, 2, 1, 1'b1);
    idle(1);

    // reset while waiting in the data phase
    addr_exp_q.push_back({30'h0000_0500, 2'b00});
    step();
    i_mem_rd = 1'b1; i_mem_addr = 30'h0000_0500; i_hprot = 4'hF; i_hready = 1'b1;
    step();
    i_hready = 1'b0;
    @(negedge i_hclk);
    check_eq("pre_rst_state", 33'(o_dbg_state), 33'(ST_DATA));
    #2 i_hnreset = 1'b0;
    #1;
    check_eq("mid_rst_htrans", 33'(o_htrans), 33'(HTRANS_IDLE));
    check_eq("mid_rst_haddr", 33'(o_haddr), 33'(0));
    check_eq("mid_rst_hprot", 33'(o_hprot), 33'(0));
    check_eq("mid_rst_outs", 33'({o_mem_ready, o_mem_err}), 33'(0));
    check_eq("mid_rst_rdata", 33'(o_mem_rdata), 33'(0));
    step();
    i_mem_rd = 1'b0; i_hready = 1'b1; i_hresp = 1'b0;
    step();
    i_hnreset = 1'b1;
    last_haddr = '0;
    idle(3);
    do_read(30'h0000_0600, 32'h6060_6060, 1'b0, 0, 0, 1'b0);
    idle(1);

    // randomized reads
    for (int n = 0; n < 8; n++) begin
      e = ($urandom_range(0, 3) == 0);
      do_read(30'($urandom), $urandom, e, $urandom_range(0, 2),
              $urandom_range(e ? 1 : 0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);

    check_eq("addr_q_drained", 33'(addr_exp_q.size()), 33'(0));
    check_eq("resp_q_drained", 33'(exp_q.size()), 33'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
